// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the ripple-carry adder leaf.
package full_adder_pkg;

    // Supported operand widths.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // Two's-complement overflow: the carry into the sign bit differs from
    // the carry out of it.
    function automatic logic signed_ovf(input logic carry_top, input logic carry_sign);
        return carry_top ^ carry_sign;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell; purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/full_adder.sv
// Parameterized ripple-carry adder with a combinational result and a
// one-cycle registered copy (sum, carry-out, signed overflow, valid).
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // Reject widths outside the supported range at elaboration.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("full_adder: WIDTH out of range");
    end

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // The combinational path is independent of clock, reset and in_valid.
    assign sum   = sum_s;
    assign cout  = carry_s[WIDTH];
    assign ovf_s = signed_ovf(carry_s[WIDTH], carry_s[WIDTH-1]);

    // Result register: clear on reset, capture on in_valid, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= {WIDTH{1'b0}};
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum_q     <= sum_s;
            cout_q    <= carry_s[WIDTH];
            ovf_q     <= ovf_s;
            out_valid <= 1'b1;
        end else begin
            sum_q     <= sum_q;
            cout_q    <= cout_q;
            ovf_q     <= ovf_q;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

    logic clk;
    logic clk_en;
    logic rst_n;

    // WIDTH=1 instance
    logic a1, b1, cin1, iv1;
    logic sum1, cout1, sum1_q, cout1_q, ovf1_q, ov1;

    // WIDTH=8 instance
    logic [7:0] a8, b8;
    logic       cin8, iv8;
    logic [7:0] sum8, sum8_q;
    logic       cout8, cout8_q, ovf8_q, ov8;

    int n_checks;
    int n_errors;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .sum(sum1), .cout(cout1), .sum_q(sum1_q), .cout_q(cout1_q),
        .ovf_q(ovf1_q), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .sum(sum8), .cout(cout8), .sum_q(sum8_q), .cout_q(cout8_q),
        .ovf_q(ovf8_q), .out_valid(ov8)
    );

    // Clock toggles only once clk_en is set, so the first phase runs clockless.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected 8-bit signed overflow from signed arithmetic.
    function automatic logic ovf8_model(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    // Drive WIDTH=8 inputs, check combinational result, then capture and check.
    task automatic vec8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        a8 = x; b8 = y; cin8 = c; iv8 = 1'b1;
        #1;
        check_val({tag, "_sum"},  {57'd0, sum8}, {57'd0, exp_sum});
        check_val({tag, "_cout"}, {64'd0, cout8}, {64'd0, exp_cout});
        tick();
        check_val({tag, "_sum_q"},  {57'd0, sum8_q}, {57'd0, exp_sum});
        check_val({tag, "_cout_q"}, {64'd0, cout8_q}, {64'd0, exp_cout});
        check_val({tag, "_ovf_q"},  {64'd0, ovf8_q}, {64'd0, exp_ovf});
        check_val({tag, "_valid"},  {64'd0, ov8}, {64'd0, 1'b1});
    endtask

    // Hand-computed WIDTH=1 truth table, indexed by {a,b,cin}: {cout,sum}.
    logic [1:0] tt1 [8];
    // Signed overflow at WIDTH=1, indexed by {a,b,cin}.
    logic       ov_tt1 [8];

    initial begin
        logic [8:0] full;
        logic [7:0] ra, rb;
        logic       rc;

        n_checks = 0;
        n_errors = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b0;

        tt1[0] = 2'b00; tt1[1] = 2'b01; tt1[2] = 2'b01; tt1[3] = 2'b10;
        tt1[4] = 2'b01; tt1[5] = 2'b10; tt1[6] = 2'b10; tt1[7] = 2'b11;
        ov_tt1[0] = 1'b0; ov_tt1[1] = 1'b1; ov_tt1[2] = 1'b0; ov_tt1[3] = 1'b0;
        ov_tt1[4] = 1'b0; ov_tt1[5] = 1'b0; ov_tt1[6] = 1'b1; ov_tt1[7] = 1'b0;

        // Exhaustive WIDTH=1 with no clock running.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            #10;
            check_val($sformatf("w1_sum_%0d", i),  {64'd0, sum1},  {64'd0, tt1[i][0]});
            check_val($sformatf("w1_cout_%0d", i), {64'd0, cout1}, {64'd0, tt1[i][1]});
        end

        // WIDTH=8 full ripple, still clockless.
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        #10;
        check_val("rip1_sum",  {57'd0, sum8}, {57'd0, 8'h00});
        check_val("rip1_cout", {64'd0, cout8}, {64'd0, 1'b1});
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        #10;
        check_val("rip2_sum",  {57'd0, sum8}, {57'd0, 8'hFF});
        check_val("rip2_cout", {64'd0, cout8}, {64'd0, 1'b1});

        // Start clock and apply reset.
        clk_en = 1'b1;
        tick();
        tick();
        check_val("rst_sum_q",  {57'd0, sum8_q}, 65'd0);
        check_val("rst_cout_q", {64'd0, cout8_q}, 65'd0);
        check_val("rst_ovf_q",  {64'd0, ovf8_q}, 65'd0);
        check_val("rst_valid",  {64'd0, ov8}, 65'd0);
        check_val("rst1_sum_q", {64'd0, sum1_q}, 65'd0);
        check_val("rst1_valid", {64'd0, ov1}, 65'd0);
        rst_n = 1'b1;
        tick();
        check_val("idle_valid", {64'd0, ov8}, 65'd0);

        // Signed overflow 0x7F + 0x01, then hold with in_valid low.
        vec8("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        iv8 = 1'b0;
        tick();
        check_val("hold_valid", {64'd0, ov8}, 65'd0);
        check_val("hold_sum_q", {57'd0, sum8_q}, {57'd0, 8'h80});
        check_val("hold_ovf_q", {64'd0, ovf8_q}, {64'd0, 1'b1});

        // More directed overflow corner cases.
        vec8("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        vec8("m1_p1",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        vec8("cin_ovf", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // Back-to-back: three consecutive captures, out_valid stays high.
        vec8("b2b0", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        vec8("b2b1", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
        vec8("b2b2", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
        iv8 = 1'b0;
        tick();
        check_val("b2b_end_valid", {64'd0, ov8}, 65'd0);

        // Reset on the second of three valid edges.
        vec8("rs0", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; iv8 = 1'b1; rst_n = 1'b0;
        tick();
        check_val("rs1_sum_q",  {57'd0, sum8_q}, 65'd0);
        check_val("rs1_cout_q", {64'd0, cout8_q}, 65'd0);
        check_val("rs1_ovf_q",  {64'd0, ovf8_q}, 65'd0);
        check_val("rs1_valid",  {64'd0, ov8}, 65'd0);
        check_val("rs1_comb",   {56'd0, cout8, sum8}, {56'd0, 9'h12C});
        rst_n = 1'b1;
        vec8("rs2", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);

        // WIDTH=1 registered path including overflow = cout ^ cin.
        iv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = 3'(i);
            iv1 = 1'b1;
            tick();
            check_val($sformatf("w1q_sum_%0d", i),  {64'd0, sum1_q},  {64'd0, tt1[i][0]});
            check_val($sformatf("w1q_cout_%0d", i), {64'd0, cout1_q}, {64'd0, tt1[i][1]});
            check_val($sformatf("w1q_ovf_%0d", i),  {64'd0, ovf1_q},  {64'd0, ov_tt1[i]});
            check_val($sformatf("w1q_valid_%0d", i), {64'd0, ov1},    {64'd0, 1'b1});
        end
        iv1 = 1'b0;

        // Pseudo-random WIDTH=8 property sweep against an arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            vec8($sformatf("rnd%0d", i), ra, rb, rc, full[7:0], full[8], ovf8_model(ra, rb, rc));
        end
        iv8 = 1'b0;
        tick();
        check_val("final_valid", {64'd0, ov8}, 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
